// File: rtl/btn_scan_pkg.sv
// Shared types and elaboration helpers for the button scan controller
// and its clock-enable prescaler.
package btn_scan_pkg;

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      SAMPLE = 2'd1,
      UPDATE = 2'd2
   } scan_state_e;

   // Width of a counter or index that must hold values 0..n-1, at least 1 bit.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic bit n_btn_ok(input int n_btn);
      return (n_btn >= 1) && (n_btn <= 16);
   endfunction

   function automatic bit deb_cnt_ok(input int deb_cnt);
      return deb_cnt >= 2;
   endfunction

   // A full scan must finish before the next tick; a short divider is
   // tolerated at run time and flagged through OVERRUN.
   function automatic bit ce_div_ok(input int n_btn, input int ce_div);
      return ce_div >= 2 * n_btn + 1;
   endfunction

endpackage

// File: rtl/btn_scan_ctrl_ce_gen.sv
// Free-running prescaler: one-cycle CE_OUT strobe every DIV clk cycles,
// asserted while the count sits at DIV-1.
module ce_gen
   import btn_scan_pkg::*;
#(
   parameter int DIV = 16
) (
   input  logic clk,
   input  logic rst,
   output logic CE_OUT
);

   localparam int PW = cnt_width(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] pcnt_q, pcnt_d;

   always_comb begin
      pcnt_d = pcnt_q + 1'b1;
      if (pcnt_q == LAST) pcnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) pcnt_q <= '0;
      else     pcnt_q <= pcnt_d;
   end

   assign CE_OUT = (pcnt_q == LAST);

endmodule

// File: rtl/btn_scan_ctrl.sv
// Time-multiplexed push-button debouncer: one shared compare/count engine
// walks all channels per scan tick. Optional BTN_SCAN_RELEASE_EN adds BTN_RELEASE.
module btn_scan_ctrl
   import btn_scan_pkg::*;
#(
   parameter int N_BTN   = 4,
   parameter int CE_DIV  = 16,
   parameter int DEB_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] BTN_IN,
   output logic [N_BTN-1:0] BTN_OUT,
   output logic [N_BTN-1:0] BTN_PRESS,
`ifdef BTN_SCAN_RELEASE_EN
   output logic [N_BTN-1:0] BTN_RELEASE,
`endif
   output logic             CE_OUT,
   output logic             SCAN_BUSY,
   output logic             OVERRUN
);

   localparam int CW = cnt_width(DEB_CNT);
   localparam int IW = cnt_width(N_BTN);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_BTN - 1);

   generate
      if (!n_btn_ok(N_BTN)) begin : g_bad_n_btn
         $error("btn_scan_ctrl: N_BTN must be 1..16");
      end
      if (!deb_cnt_ok(DEB_CNT)) begin : g_bad_deb_cnt
         $error("btn_scan_ctrl: DEB_CNT must be >= 2");
      end
   endgenerate

   logic [N_BTN-1:0]          sync1_q, sync2_q;
   scan_state_e               state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic                      smp_q, smp_d;
   logic [N_BTN-1:0]          stable_q, stable_d;
   logic [N_BTN-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [N_BTN-1:0]          press_q, press_d;
   logic                      ovr_q, ovr_d;
   logic                      cur_stable;
   logic [CW-1:0]             cur_cnt;
`ifdef BTN_SCAN_RELEASE_EN
   logic [N_BTN-1:0]          rel_q, rel_d;
`endif

   ce_gen #(.DIV(CE_DIV)) u_ce_gen (
      .clk    (clk),
      .rst    (rst),
      .CE_OUT (CE_OUT)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= BTN_IN;
         sync2_q <= sync1_q;
      end
   end

   assign cur_stable = stable_q[idx_q];
   assign cur_cnt    = cnt_q[idx_q];

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      smp_d    = smp_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      press_d  = '0;
`ifdef BTN_SCAN_RELEASE_EN
      rel_d    = '0;
`endif
      // A tick landing mid-scan is dropped; the scan in progress still completes.
      ovr_d    = ovr_q | (CE_OUT & (state_q != WAIT));
      case (state_q)
         WAIT: begin
            idx_d = '0;
            if (CE_OUT) state_d = SAMPLE;
         end
         SAMPLE: begin
            smp_d   = sync2_q[idx_q];
            state_d = UPDATE;
         end
         UPDATE: begin
            if (smp_q == cur_stable) begin
               cnt_d[idx_q] = '0;
            end else if (cur_cnt < CNT_LAST) begin
               cnt_d[idx_q] = cur_cnt + 1'b1;
            end else begin
               stable_d[idx_q] = smp_q;
               cnt_d[idx_q]    = '0;
               press_d[idx_q]  = smp_q;
`ifdef BTN_SCAN_RELEASE_EN
               rel_d[idx_q]    = ~smp_q;
`endif
            end
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               state_d = WAIT;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = SAMPLE;
            end
         end
         default: begin
            idx_d   = '0;
            state_d = WAIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WAIT;
         idx_q    <= '0;
         smp_q    <= 1'b0;
         stable_q <= '0;
         cnt_q    <= '0;
         press_q  <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         smp_q    <= smp_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
         ovr_q    <= ovr_d;
      end
   end

`ifdef BTN_SCAN_RELEASE_EN
   always_ff @(posedge clk) begin
      if (rst) rel_q <= '0;
      else     rel_q <= rel_d;
   end

   assign BTN_RELEASE = rel_q;
`endif

   assign BTN_OUT   = stable_q;
   assign BTN_PRESS = press_q;
   assign OVERRUN   = ovr_q;
   assign SCAN_BUSY = (state_q != WAIT);

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Scoreboard bench for btn_scan_ctrl: main instance (4 ch, CE_DIV=16, DEB_CNT=4)
// plus a CE_DIV=8 instance for overrun. Release pulses checked when BTN_SCAN_RELEASE_EN is set.
module tb_btn_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_in;
   logic [3:0] btn_out, btn_press;
   logic       ce, busy, ovr;
   logic [3:0] ov_out, ov_press;
   logic       ov_ce, ov_busy, ov_ovr;
`ifdef BTN_SCAN_RELEASE_EN
   logic [3:0] btn_rel, ov_rel;
`endif

   always #5 clk = ~clk;

   btn_scan_ctrl #(.N_BTN(4), .CE_DIV(16), .DEB_CNT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .BTN_IN      (btn_in),
      .BTN_OUT     (btn_out),
      .BTN_PRESS   (btn_press),
`ifdef BTN_SCAN_RELEASE_EN
      .BTN_RELEASE (btn_rel),
`endif
      .CE_OUT      (ce),
      .SCAN_BUSY   (busy),
      .OVERRUN     (ovr)
   );

   btn_scan_ctrl #(.N_BTN(4), .CE_DIV(8), .DEB_CNT(4)) dut_ov (
      .clk         (clk),
      .rst         (rst),
      .BTN_IN      (btn_in),
      .BTN_OUT     (ov_out),
      .BTN_PRESS   (ov_press),
`ifdef BTN_SCAN_RELEASE_EN
      .BTN_RELEASE (ov_rel),
`endif
      .CE_OUT      (ov_ce),
      .SCAN_BUSY   (ov_busy),
      .OVERRUN     (ov_ovr)
   );

   typedef struct {
      int at;
      int idx;
      bit rel;
   } ev_t;

   ev_t exp_q[$];
   int  n_chk  = 0;
   int  n_fail = 0;
   int  n      = 0;
   bit  mon_en = 1'b0;

   // Cycle count since the last reset edge; prescalers are at n mod CE_DIV.
   always @(posedge clk) begin
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (n=%0d)", tag, got, exp, n);
      end
   endtask

   function automatic int ev_code(input bit rel, input int idx, input int at);
      return (int'(rel) << 30) | (idx << 24) | at;
   endfunction

   task automatic push_press(input int at, input int idx);
      ev_t e;
      e.at = at; e.idx = idx; e.rel = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic push_rel(input int at, input int idx);
`ifdef BTN_SCAN_RELEASE_EN
      ev_t e;
      e.at = at; e.idx = idx; e.rel = 1'b1;
      exp_q.push_back(e);
`else
      if (at < 0 || idx < 0) $display("bad release event");
`endif
   endtask

   task automatic got_ev(input bit rel, input int idx);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("ev_unexpected", ev_code(rel, idx, n), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         chk("ev", ev_code(rel, idx, n), ev_code(e.rel, e.idx, e.at));
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("ce", 32'(ce), 32'((n % 16) == 15));
         chk("ce_ov", 32'(ov_ce), 32'((n % 8) == 7));
         chk("press_onehot", 32'($countones(btn_press) <= 1), 32'd1);
         for (int i = 0; i < 4; i++) begin
            if (btn_press[i]) got_ev(1'b0, i);
`ifdef BTN_SCAN_RELEASE_EN
            if (btn_rel[i]) got_ev(1'b1, i);
`endif
         end
         if (exp_q.size() > 0 && n > exp_q[0].at) begin
            chk("ev_missed", n, exp_q[0].at);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic wait_n(input int target);
      int g;
      g = 0;
      while (n != target && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (n != target) chk("wait_timeout", n, target);
   endtask

   // Returns at the negedge of the next tick cycle of the main instance.
   task automatic to_tick(output int t);
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while ((n % 16) != 15 && g < 100);
      if ((n % 16) != 15) chk("tick_timeout", n % 16, 15);
      chk("busy_at_tick", 32'(busy), 32'd0);
      t = n;
   endtask

   int t;

   initial begin
      rst    = 1'b1;
      btn_in = 4'b1111;
      repeat (3) begin
         @(negedge clk);
         chk("rst_out", 32'({btn_out, btn_press, ce, busy, ovr}), 32'd0);
         chk("rst_ov", 32'({ov_out, ov_press, ov_ce, ov_busy, ov_ovr}), 32'd0);
      end
      rst    = 1'b0;
      mon_en = 1'b1;

      // all four held high through reset: flip on the 4th tick (n=63)
      for (int i = 0; i < 4; i++) push_press(66 + 2 * i, i);
      wait_n(14);
      chk("pre_first_ce", 32'(ce), 32'd0);
      wait_n(15);
      chk("first_ce", 32'(ce), 32'd1);
      chk("ovr_before_2nd_tick", 32'(ov_ovr), 32'd0);
      wait_n(16);
      chk("ovr_set", 32'(ov_ovr), 32'd1);
      wait_n(65);
      chk("out_before_4th", 32'(btn_out), 32'h0);
      wait_n(66);
      chk("out_ch0", 32'(btn_out), 32'h1);
      wait_n(72);
      chk("out_all", 32'(btn_out), 32'hF);

      // release all
      to_tick(t);
      wait_n(t + 10);
      btn_in = 4'b0000;
      for (int i = 0; i < 4; i++) push_rel(t + 67 + 2 * i, i);
      wait_n(t + 72);
      chk("rel_partial", 32'(btn_out), 32'h8);
      wait_n(t + 73);
      chk("rel_all", 32'(btn_out), 32'h0);

      // clean press on ch2
      to_tick(t);
      wait_n(t + 10);
      btn_in[2] = 1'b1;
      push_press(t + 71, 2);
      wait_n(t + 70);
      chk("clean_before", 32'(btn_out), 32'h0);
      wait_n(t + 71);
      chk("clean_after", 32'(btn_out), 32'h4);

      // bounce on ch1: high 15 / 25 / 5 cycles, separated by 20 low
      btn_in[1] = 1'b1; repeat (15) @(negedge clk);
      btn_in[1] = 1'b0; repeat (20) @(negedge clk);
      btn_in[1] = 1'b1; repeat (25) @(negedge clk);
      btn_in[1] = 1'b0; repeat (20) @(negedge clk);
      btn_in[1] = 1'b1; repeat (5)  @(negedge clk);
      btn_in[1] = 1'b0; repeat (100) @(negedge clk);
      chk("bounce_out", 32'(btn_out), 32'h4);

      // simultaneous rise on ch0 and ch3
      to_tick(t);
      wait_n(t + 10);
      btn_in[0] = 1'b1;
      btn_in[3] = 1'b1;
      push_press(t + 67, 0);
      push_press(t + 73, 3);
      wait_n(t + 67);
      chk("simul_ch0", 32'(btn_out), 32'h5);
      wait_n(t + 73);
      chk("simul_ch3", 32'(btn_out), 32'hD);

      // release ch0, ch2, ch3
      to_tick(t);
      wait_n(t + 10);
      btn_in = 4'b0000;
      push_rel(t + 67, 0);
      push_rel(t + 71, 2);
      push_rel(t + 73, 3);
      wait_n(t + 73);
      chk("rel2_all", 32'(btn_out), 32'h0);

      // reset in the UPDATE cycle where ch2 would flip
      to_tick(t);
      wait_n(t + 10);
      btn_in[2] = 1'b1;
      wait_n(t + 70);
      chk("busy_in_update", 32'(busy), 32'd1);
      chk("ovr_sticky", 32'(ov_ovr), 32'd1);
      chk("out_before_abort", 32'(btn_out), 32'h0);
      rst    = 1'b1;
      btn_in = 4'b0000;
      @(negedge clk);
      chk("abort_out", 32'(btn_out), 32'h0);
      chk("abort_press", 32'(btn_press), 32'h0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ovr", 32'(ov_ovr), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("after_abort_press", 32'(btn_press), 32'h0);
      wait_n(15);
      chk("ovr_clear_until_tick2", 32'(ov_ovr), 32'd0);
      wait_n(16);
      chk("ovr_reset_again", 32'(ov_ovr), 32'd1);
      wait_n(90);
      chk("abort_no_flip", 32'(btn_out), 32'h0);

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
